// File: rtl/fpdiv_round.sv
// Post-iteration stage of the binary32 Goldschmidt divider: normalize, round, pack, flags.
// Define FPDIV_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to signed zero.
module fpdiv_round #(
    parameter int unsigned QW = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [9:0]    in_exp,
    input  logic [QW-1:0] in_q,
    input  logic          in_rem_neg,
    input  logic          in_rem_zero,
    input  logic [2:0]    in_special,
    input  logic [1:0]    in_rm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic [4:0]    out_flags
);

    localparam logic [1:0] RmRne = 2'b00;
    localparam logic [1:0] RmRz  = 2'b01;
    localparam logic [1:0] RmRdn = 2'b10;

    localparam logic [2:0] SpZero  = 3'b001;
    localparam logic [2:0] SpInf   = 3'b010;
    localparam logic [2:0] SpInval = 3'b011;
    localparam logic [2:0] SpQnan  = 3'b100;
    localparam logic [2:0] SpDivZ  = 3'b101;

    localparam logic [4:0] FlagNv = 5'b10000;
    localparam logic [4:0] FlagDz = 5'b01000;
    localparam logic [4:0] FlagOf = 5'b00100;
    localparam logic [4:0] FlagUf = 5'b00010;
    localparam logic [4:0] FlagNx = 5'b00001;

    localparam logic [31:0] QnanBits = 32'h7FC0_0000;

    function automatic logic round_up(input logic [1:0] rm, input logic sign, input logic lsb,
                                      input logic g, input logic s);
        logic up;
        case (rm)
            RmRne:   up = g & (s | lsb);
            RmRz:    up = 1'b0;
            RmRdn:   up = sign & (g | s);
            default: up = ~sign & (g | s);
        endcase
        return up;
    endfunction

    // Pipeline state
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q, s1_sign_d;
    logic signed [11:0] s1_exp_q, s1_exp_d;
    logic [22:0]        s1_mant_q, s1_mant_d;
    logic               s1_guard_q, s1_guard_d;
    logic               s1_sticky_q, s1_sticky_d;
    logic [1:0]         s1_rm_q, s1_rm_d;
    logic [2:0]         s1_special_q, s1_special_d;
    logic               s2_valid_q, s2_valid_d;
    logic [31:0]        res_q, res_d;
    logic [4:0]         flags_q, flags_d;

    logic s1_adv, s1_load, s2_load;

    assign s1_adv     = ~s2_valid_q | out_ready;
    assign in_ready   = ~s1_valid_q | s1_adv;
    assign s1_load    = in_valid & in_ready;
    assign s2_load    = s1_adv & s1_valid_q;
    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_flags  = flags_q;

    // Stage 1: remainder correction and one-bit normalization
    logic [QW-1:0]      q_adj;
    logic [QW-3:0]      q_norm;
    logic               norm_top;
    logic signed [11:0] exp_ext;
    logic signed [11:0] exp_norm;
    logic               unused_q_msb;

    // The integer '2' bit is never set for in-range quotients.
    assign unused_q_msb = q_adj[QW-1];

    always_comb begin
        q_adj    = in_q - {{(QW-1){1'b0}}, in_rem_neg};
        norm_top = q_adj[QW-2];
        q_norm   = norm_top ? q_adj[QW-3:0] : {q_adj[QW-4:0], 1'b0};
        exp_ext  = {{2{in_exp[9]}}, in_exp};
        exp_norm = norm_top ? exp_ext : exp_ext - 12'sd1;
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_mant_d    = s1_mant_q;
        s1_guard_d   = s1_guard_q;
        s1_sticky_d  = s1_sticky_q;
        s1_rm_d      = s1_rm_q;
        s1_special_d = s1_special_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (s1_load) begin
            s1_sign_d    = in_sign;
            s1_exp_d     = exp_norm;
            s1_mant_d    = q_norm[QW-3 -: 23];
            s1_guard_d   = q_norm[QW-26];
            s1_sticky_d  = (|q_norm[QW-27:0]) | ~in_rem_zero;
            s1_rm_d      = in_rm;
            s1_special_d = in_special;
        end
    end

    // Stage 2: rounding, range handling and packing
    logic               gs;
    logic               inc;
    logic [23:0]        mant_sum;
    logic signed [11:0] exp_rnd;
    logic               ovf_inf;
    logic [31:0]        pack_res;
    logic [4:0]         pack_flags;
`ifdef FPDIV_SUBNORMAL_EN
    logic [4:0]         sub_shift;
    logic [50:0]        sub_vec;
    logic               sub_g;
    logic               sub_s;
    logic               sub_inc;
    logic [23:0]        sub_sum;
`endif

    always_comb begin
        gs       = s1_guard_q | s1_sticky_q;
        inc      = round_up(s1_rm_q, s1_sign_q, s1_mant_q[0], s1_guard_q, s1_sticky_q);
        mant_sum = {1'b0, s1_mant_q} + {23'd0, inc};
        exp_rnd  = mant_sum[23] ? s1_exp_q + 12'sd1 : s1_exp_q;
        ovf_inf  = (s1_rm_q == RmRne) | ((s1_rm_q == RmRdn) & s1_sign_q)
                 | ((s1_rm_q == 2'b11) & ~s1_sign_q);
`ifdef FPDIV_SUBNORMAL_EN
        // Denormalizing shift is capped: beyond 26 places everything is sticky anyway.
        sub_shift = (s1_exp_q < -12'sd25) ? 5'd26 : 5'(12'sd1 - s1_exp_q);
        sub_vec   = {1'b1, s1_mant_q, s1_guard_q, 26'd0} >> sub_shift;
        sub_g     = sub_vec[26];
        sub_s     = (|sub_vec[25:0]) | s1_sticky_q;
        sub_inc   = round_up(s1_rm_q, s1_sign_q, sub_vec[27], sub_g, sub_s);
        sub_sum   = sub_vec[50:27] + {23'd0, sub_inc};
`endif

        pack_res   = 32'd0;
        pack_flags = 5'd0;
        if (s1_exp_q <= 12'sd0) begin
`ifdef FPDIV_SUBNORMAL_EN
            // A carry into bit 23 lands on the smallest normal; UF still reported.
            pack_res   = {s1_sign_q, 7'd0, sub_sum};
            pack_flags = (sub_g | sub_s) ? (FlagUf | FlagNx) : 5'd0;
`else
            pack_res   = {s1_sign_q, 31'd0};
            pack_flags = FlagUf | FlagNx;
`endif
        end else if (exp_rnd >= 12'sd255) begin
            pack_res   = ovf_inf ? {s1_sign_q, 8'hFF, 23'd0} : {s1_sign_q, 31'h7F7F_FFFF};
            pack_flags = FlagOf | FlagNx;
        end else begin
            pack_res   = {s1_sign_q, exp_rnd[7:0], mant_sum[22:0]};
            pack_flags = gs ? FlagNx : 5'd0;
        end

        case (s1_special_q)
            SpZero: begin
                pack_res   = {s1_sign_q, 31'd0};
                pack_flags = 5'd0;
            end
            SpInf: begin
                pack_res   = {s1_sign_q, 8'hFF, 23'd0};
                pack_flags = 5'd0;
            end
            SpInval: begin
                pack_res   = QnanBits;
                pack_flags = FlagNv;
            end
            SpQnan: begin
                pack_res   = QnanBits;
                pack_flags = 5'd0;
            end
            SpDivZ: begin
                pack_res   = {s1_sign_q, 8'hFF, 23'd0};
                pack_flags = FlagDz;
            end
            default: ;
        endcase
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        flags_d    = flags_q;
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            res_d   = pack_res;
            flags_d = pack_flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= 12'sd0;
            s1_mant_q    <= 23'd0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_rm_q      <= 2'b00;
            s1_special_q <= 3'b000;
            s2_valid_q   <= 1'b0;
            res_q        <= 32'd0;
            flags_q      <= 5'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_mant_q    <= s1_mant_d;
            s1_guard_q   <= s1_guard_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_rm_q      <= s1_rm_d;
            s1_special_q <= s1_special_d;
            s2_valid_q   <= s2_valid_d;
            res_q        <= res_d;
            flags_q      <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpdiv_round.sv
// Self-checking bench for fpdiv_round: directed corner cases, backpressure/reset, then
// randomized traffic scored against an arithmetic reference model.
module tb_fpdiv_round;
    localparam int QW = 30;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [9:0]    in_exp;
    logic [QW-1:0] in_q;
    logic          in_rem_neg;
    logic          in_rem_zero;
    logic [2:0]    in_special;
    logic [1:0]    in_rm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_result;
    logic [4:0]    out_flags;

    always #5 clk = ~clk;

    fpdiv_round #(.QW(QW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_q       (in_q),
        .in_rem_neg (in_rem_neg),
        .in_rem_zero(in_rem_zero),
        .in_special (in_special),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          last_lat = -1;
    logic [31:0] exp_res[$];
    logic [4:0]  exp_flg[$];
    int          exp_cyc[$];
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_res;
    logic [4:0]  fixed_flg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit rnd_up(input logic [1:0] rm, input bit sg, input bit lsb,
                                  input bit g, input bit s);
        case (rm)
            2'b00:   return g && (s || lsb);
            2'b01:   return 1'b0;
            2'b10:   return sg && (g || s);
            default: return !sg && (g || s);
        endcase
    endfunction

    // Reference: quotient as an integer significand, rounded with plain arithmetic.
    function automatic void model(input logic sg, input logic [9:0] ex, input logic [QW-1:0] q,
                                  input logic rn, input logic rz, input logic [2:0] sp,
                                  input logic [1:0] rm, output logic [31:0] r,
                                  output logic [4:0] f);
        longint qa, sig, x, m;
        int     e, rest, k;
        bit     g, s, g2, s2, inf;
        r = 32'd0;
        f = 5'd0;
        case (sp)
            3'd1: begin r = {sg, 31'd0}; return; end
            3'd2: begin r = {sg, 31'h7F80_0000}; return; end
            3'd3: begin r = 32'h7FC0_0000; f = 5'b10000; return; end
            3'd4: begin r = 32'h7FC0_0000; return; end
            3'd5: begin r = {sg, 31'h7F80_0000}; f = 5'b01000; return; end
            default: ;
        endcase
        qa = longint'(q) - longint'(rn);
        e  = int'($signed(ex));
        if (qa < 64'sd268435456) begin
            qa = qa * 2;
            e  = e - 1;
        end
        sig  = qa / 32;
        rest = int'(qa % 32);
        g    = (rest >= 16);
        s    = ((rest % 16) != 0) || !rz;
        if (e <= 0) begin
`ifdef FPDIV_SUBNORMAL_EN
            k  = (1 - e > 26) ? 26 : 1 - e;
            x  = sig * 2 + (g ? 1 : 0);
            m  = x >> (k + 1);
            g2 = ((x >> k) % 2) != 0;
            s2 = ((x % (64'sd1 << k)) != 0) || s;
            m  = m + (rnd_up(rm, sg, (m % 2) != 0, g2, s2) ? 1 : 0);
            r  = {sg, 31'(m)};
            f  = (g2 || s2) ? 5'b00011 : 5'b00000;
`else
            r = {sg, 31'd0};
            f = 5'b00011;
`endif
            return;
        end
        sig = sig + (rnd_up(rm, sg, (sig % 2) != 0, g, s) ? 1 : 0);
        if (sig >= 64'sd16777216) begin
            sig = sig / 2;
            e   = e + 1;
        end
        if (e >= 255) begin
            inf = (rm == 2'b00) || (rm == 2'b10 && sg) || (rm == 2'b11 && !sg);
            r   = inf ? {sg, 31'h7F80_0000} : {sg, 31'h7F7F_FFFF};
            f   = 5'b00101;
        end else begin
            r = {sg, 8'(e), 23'(sig)};
            f = {4'b0000, g || s};
        end
    endfunction

    // One clock: score outputs and record accepted inputs mid-cycle, then step past the edge.
    task automatic cycle();
        logic [31:0] r;
        logic [4:0]  f;
        int          c0;
        @(negedge clk);
        if (out_valid) begin
            if (exp_res.size() == 0) begin
                check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                check("result", out_result, exp_res[0]);
                check("flags", {27'd0, out_flags}, {27'd0, exp_flg[0]});
                if (out_ready) begin
                    r = exp_res.pop_front();
                    f = exp_flg.pop_front();
                    c0 = exp_cyc.pop_front();
                    last_lat = cyc - c0;
                end
            end
        end
        if (in_valid && in_ready) begin
            n_acc++;
            if (use_fixed) begin
                r = fixed_res;
                f = fixed_flg;
            end else begin
                model(in_sign, in_exp, in_q, in_rem_neg, in_rem_zero, in_special, in_rm, r, f);
            end
            exp_res.push_back(r);
            exp_flg.push_back(f);
            exp_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input logic sg, input logic [9:0] ex, input logic [QW-1:0] q,
                          input logic rn, input logic rz, input logic [2:0] sp,
                          input logic [1:0] rm);
        in_sign     = sg;
        in_exp      = ex;
        in_q        = q;
        in_rem_neg  = rn;
        in_rem_zero = rz;
        in_special  = sp;
        in_rm       = rm;
    endtask

    task automatic send_fixed(input string tag, input logic sg, input logic [9:0] ex,
                              input logic [QW-1:0] q, input logic rn, input logic rz,
                              input logic [2:0] sp, input logic [1:0] rm,
                              input logic [31:0] er, input logic [4:0] ef);
        set_in(sg, ex, q, rn, rz, sp, rm);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        use_fixed = 1'b1;
        fixed_res = er;
        fixed_flg = ef;
        cycle();
        in_valid  = 1'b0;
        use_fixed = 1'b0;
        repeat (3) cycle();
        check({tag, "_drained"}, exp_res.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 10'd0, '0, 1'b0, 1'b1, 3'd0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", {27'd0, out_flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_fixed("one", 1'b0, 10'd127, 30'h1000_0000, 1'b0, 1'b1, 3'd0, 2'b00,
                   32'h3F80_0000, 5'b00000);
        check("latency", last_lat, 32'd2);
        send_fixed("tie_rne", 1'b0, 10'd127, 30'h1000_0010, 1'b0, 1'b1, 3'd0, 2'b00,
                   32'h3F80_0000, 5'b00001);
        send_fixed("tie_rup", 1'b0, 10'd127, 30'h1000_0010, 1'b0, 1'b1, 3'd0, 2'b11,
                   32'h3F80_0001, 5'b00001);
        send_fixed("remneg", 1'b0, 10'd127, 30'h1000_0000, 1'b1, 1'b0, 3'd0, 2'b01,
                   32'h3F7F_FFFF, 5'b00001);
        send_fixed("ovf_rz", 1'b0, 10'd255, 30'h1000_0000, 1'b0, 1'b1, 3'd0, 2'b01,
                   32'h7F7F_FFFF, 5'b00101);
        send_fixed("ovf_rne", 1'b0, 10'd255, 30'h1000_0000, 1'b0, 1'b1, 3'd0, 2'b00,
                   32'h7F80_0000, 5'b00101);
        send_fixed("divzero", 1'b1, 10'd127, 30'h1000_0000, 1'b0, 1'b1, 3'd5, 2'b00,
                   32'hFF80_0000, 5'b01000);
        send_fixed("invalid", 1'b1, 10'd127, 30'h1000_0000, 1'b0, 1'b1, 3'd3, 2'b10,
                   32'h7FC0_0000, 5'b10000);
`ifdef FPDIV_SUBNORMAL_EN
        send_fixed("tiny", 1'b0, 10'd0, 30'h1000_0000, 1'b0, 1'b1, 3'd0, 2'b00,
                   32'h0040_0000, 5'b00000);
`else
        send_fixed("tiny", 1'b0, 10'd0, 30'h1000_0000, 1'b0, 1'b1, 3'd0, 2'b00,
                   32'h0000_0000, 5'b00011);
`endif

        // Stall the consumer with a continuous producer: only two operations fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(1'b1, 10'd100, 30'h1234_5678, 1'b0, 1'b0, 3'd0, 2'b00);
        n_acc = 0;
        repeat (4) cycle();
        check("bp_accepted", n_acc, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);

        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_result", out_result, 32'd0);
        exp_res.delete();
        exp_flg.delete();
        exp_cyc.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) begin
            cycle();
            check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            ev = int'($urandom_range(0, 300)) - 30;
            in_sign     = 1'($urandom_range(0, 1));
            in_exp      = 10'(ev);
            in_q        = 30'($urandom_range(32'h0800_0001, 32'h1FFF_FFFF));
            if ($urandom_range(0, 3) == 0) in_q[4:0] = 5'b10000;
            in_rem_neg  = 1'($urandom_range(0, 1));
            in_rem_zero = in_rem_neg ? 1'b0 : 1'($urandom_range(0, 1));
            in_special  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
            in_rm       = 2'($urandom_range(0, 3));
            cycle();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_res.size() != 0; i++) cycle();
        check("final_drain", exp_res.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpdiv_round.md
Name: fpdiv_round

Overview:
- Post-iteration stage of the single-precision Goldschmidt divider.
- Consumes the raw quotient mantissa, pre-exponent, sign and remainder-check result produced once the iterations complete.
- Normalizes, applies the rounding mode, handles special cases, and packs an IEEE-754 binary32 result plus exception flags.
- Two-stage pipeline with valid/ready backpressure toward the result consumer.

Parameters:
- QW, 30, quotient width; fixed-point format 2.(QW-2), valid range [0.5, 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- in_valid  in  1  divider has a completed quotient.
- in_ready  out  1  stage can accept a quotient this cycle.
- in_sign  in  1  result sign (sign_a XOR sign_b).
- in_exp  in  10  signed pre-exponent: ea - eb + 127.
- in_q  in  QW  truncated quotient mantissa, 2.(QW-2).
- in_rem_neg  in  1  remainder N - Q*D negative: q is 1 LSB too large.
- in_rem_zero  in  1  remainder exactly zero.
- in_special  in  3  000 normal, 001 zero, 010 infinity, 011 invalid, 100 quiet-NaN operand, 101 divide-by-zero.
- in_rm  in  2  00 RNE, 01 RZ, 10 RDN, 11 RUP.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  packed binary32.
- out_flags  out  5  {NV, DZ, OF, UF, NX}.

Behaviour:
- Reset: s1/s2 valid=0; out_valid=0, out_result=0, out_flags=0. in_ready=1 once reset deasserts.
- Handshake:
  - Transfer occurs on in_valid&in_ready, or out_valid&out_ready.
  - in_ready = !s1_valid | (s1 advances this cycle).
  - s1 advances when !s2_valid | out_ready.
  - Full throughput of 1/cycle; latency exactly 2 cycles from input transfer to out_valid when unstalled.
  - Held outputs (result, flags) stay stable while out_valid & !out_ready.
- Stage 1 (normalize):
  - q' = in_q - in_rem_neg.
  - If q'[QW-2]=1: mant = q'[QW-3 -: 23], e = in_exp.
  - Else: shift left 1, e = in_exp - 1.
  - guard = next bit below mant.
  - sticky = OR of remaining bits | !in_rem_zero.
  - Register sign, e, mant, guard, sticky, rm, special.
- Stage 2 (round/pack):
  - RNE: inc = g & (s | lsb).
  - RZ: inc = 0.
  - RDN: inc = sign & (g|s).
  - RUP: inc = !sign & (g|s).
  - Mantissa carry-out sets mant=0, e+1.
  - NX = g|s.
  - Overflow (e >= 255 after rounding):
    - OF|NX set.
    - Result is infinity for RNE, RDN-negative, RUP-positive; otherwise 0x7F7FFFFF with sign.
  - Underflow (e <= 0): behaviour set by the optional feature below.
- Specials override arithmetic and ignore rm:
  - 001 → signed zero, flags 0.
  - 010 → signed infinity, flags 0.
  - 011 → 0x7FC00000, NV.
  - 100 → 0x7FC00000, flags 0.
  - 101 → signed infinity, DZ.
- Async reset mid-operation clears both stages immediately. Any in-flight operation is lost and produces no output.

Optional Feature:
- Macro FPDIV_SUBNORMAL_EN.
- Defined: when e <= 0, stage 2 right-shifts {1,mant,g} by min(1-e, 26) with sticky accumulation, then rounds and packs with exponent field 0.
  - UF is set when the result is tiny and inexact.
  - Rounding up to 0x00800000 keeps UF.
- Undefined: e <= 0 flushes to signed zero with UF|NX, regardless of rm.

Test Plan:
- 1.0/1.0: sign=0, exp=127, q=0x10000000, rem_zero=1, rm=00 → out_result 0x3F800000, flags 0, out_valid exactly 2 cycles after transfer.
- Tie case: q with lsb=0, guard=1, other bits 0, rem_zero=1, exp=127, rm=00 → no increment, NX=1; same input with rm=11 → mantissa+1, NX=1.
- rem_neg=1 with q=0x10000000 → normalizes via left shift, exp 126, mantissa all ones, NX=1 (rm=01 → 0x3F7FFFFF).
- Overflow: exp=255, q=0x10000000, rm=01 → 0x7F7FFFFF, flags OF|NX; rm=00 → 0x7F800000.
- Specials: in_special=101, sign=1 → 0xFF800000, DZ; 011 → 0x7FC00000, NV.
- Backpressure/reset: out_ready=0 for 3 cycles while in_valid held → exactly 2 transfers accepted, in_ready=0, out_result stable. Assert reset low mid-stall → out_valid=0 asynchronously, no stale result after release.
